// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU sequencer: opcodes, FSM encoding
// and the bit-counter width helper.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_XNOR = 3'b111;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int cnt_width(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// Combinational 1-bit ALU slice: full adder for ADD/SUB plus bitwise logic ops.
// Operand inversion for SUB is done by the sequencer, not here.
module alu_serial_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] sel,
  output logic       r,
  output logic       cout
);

  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    case (sel)
      OP_ADD, OP_SUB: begin
        r    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu16_serial_seq.sv
// Bit-serial ALU sequencer: one operation per valid/ready handshake, LSB-first.
// Optional signed-overflow output enabled by defining ALU_SERIAL_OVF_EN.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// RUN   | shifting one bit per cycle through the slice
// DONE  | result/flags held, out_valid=1 until out_ready
module alu16_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err,
`ifdef ALU_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [2:0]       r_sel;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cy;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_zero;
  logic             r_err;
  logic             r_ovf;

  logic             w_b_in;
  logic             w_bit;
  logic             w_cout;
  logic             w_arith;
  logic             w_arith_req;
  logic             w_unsup_req;
  logic [WIDTH-1:0] w_res_next;

  assign w_arith     = (r_sel == OP_ADD) || (r_sel == OP_SUB);
  assign w_arith_req = (sel == OP_ADD) || (sel == OP_SUB);
  assign w_unsup_req = (sel == OP_MUL) || (sel == OP_DIV);
  assign w_b_in      = (r_sel == OP_SUB) ? ~r_b_sh[0] : r_b_sh[0];
  assign w_res_next  = {w_bit, r_res_sh[WIDTH-1:1]};

  alu_serial_slice u_slice (
    .a    (r_a_sh[0]),
    .b    (w_b_in),
    .cin  (r_cy),
    .sel  (r_sel),
    .r    (w_bit),
    .cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_sel    <= OP_ADD;
      r_cnt    <= '0;
      r_cy     <= 1'b0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh   <= op_a;
            r_b_sh   <= op_b;
            r_sel    <= sel;
            r_cnt    <= '0;
            r_cy     <= (sel == OP_SUB);
            r_res_sh <= '0;
            r_err    <= w_unsup_req;
            if (w_unsup_req) begin
              r_result <= '0;
              r_carry  <= 1'b0;
              r_zero   <= 1'b1;
              r_ovf    <= 1'b0;
              r_state  <= DONE;
            end else begin
              r_state  <= RUN;
            end
          end
        end
        RUN: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_res_sh <= w_res_next;
          r_cy     <= w_arith ? w_cout : 1'b0;
          r_cnt    <= r_cnt + 1'b1;
          // Last bit: publish the result; r_cy is the carry into the MSB here.
          if (r_cnt == CNT_LAST) begin
            r_result <= w_res_next;
            r_carry  <= w_arith ? w_cout : 1'b0;
            r_zero   <= (w_res_next == '0);
            r_ovf    <= w_arith ? (r_cy ^ w_cout) : 1'b0;
            r_state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = r_zero;
  assign err       = r_err;

`ifdef ALU_SERIAL_OVF_EN
  assign ovf = r_ovf;
`else
  logic w_ovf_unused;
  assign w_ovf_unused = r_ovf ^ w_arith_req;
`endif

endmodule

// File: doc/alu16_serial_seq.md
Name: alu16_serial_seq

Overview:
- Bit-serial sequencer sitting directly upstream of the 1-bit ALU slice: accepts one 16-bit operation per transaction, feeds operands LSB-first into a 1-bit slice, chains carry between cycles, and assembles the 16-bit result and flags.
- Valid/ready on both sides.
- Trades latency (WIDTH cycles) for a single-bit datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; legal range 2 or more.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request (IDLE only)
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- sel  in  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 XNOR
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  assembled result
- carry  out  1  final carry (ADD/SUB), else 0
- zero  out  1  result == 0
- err  out  1  unsupported opcode (MUL/DIV)
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE immediately.
  - result=0, carry=0, zero=0, err=0, out_valid=0, busy=0, in_ready=1.
  - Internal operand/shift registers and bit counter are cleared.
  - Asserting reset mid-RUN or in DONE aborts the transaction; no output is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch op_a, op_b and sel. Set bit counter to 0. Initialise the carry register to 1 for SUB, else 0.
  - Next state is RUN for ADD/SUB/logic ops, DONE with err=1 and result=0 for 010/011.
- RUN, one bit per cycle:
  - The slice gets a_sh[0], b_sh[0] (inverted for SUB) and the carry register.
  - Slice output bit shifts into result at the MSB; result shifts right by 1.
  - a_sh and b_sh shift right by 1.
  - The carry register takes slice cout for ADD/SUB and stays 0 for logic ops.
  - The counter increments. When the counter reaches WIDTH-1, the next state is DONE.
- Latency: out_valid rises exactly WIDTH cycles after the accepting edge. For 010/011 it rises 1 cycle after.
- DONE:
  - out_valid=1.
  - result, carry, zero and err are held stable.
  - On out_ready=1, go to IDLE next edge; out_valid drops and in_ready rises.
  - No bypass: a new request is never accepted in the same cycle a result is consumed.
- in_valid is ignored in RUN and DONE; in_ready=0 there.
- Arithmetic:
  - SUB is two's complement, A + ~B + 1.
  - carry=1 on SUB means no borrow (A >= B unsigned).
  - zero is computed from the final result and is also valid for logic ops.
  - result is undefined-free: it holds the last value until the next DONE, and is cleared only by reset.
- err is cleared on the next accepted request.

Optional Feature:
- Macro ALU_SERIAL_OVF_EN.
- When defined:
  - Extra output port ovf (1 bit).
  - ovf = signed overflow for ADD/SUB, computed as the carry into the MSB XOR the carry out of the MSB, captured on the last RUN cycle.
  - ovf is 0 for logic and unsupported ops; reset value 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_ADD=3'b000 … OP_XNOR=3'b111)
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - counter width function, clog2(WIDTH)
- Sub-module alu_serial_slice: purely combinational 1-bit slice with inputs a, b, cin, sel and outputs r, cout (full adder plus AND/OR/XOR/XNOR). Instantiated once.
- The sequencer holds all state.

Test Plan:
1. ADD 0x1234+0x0FF0, out_ready=1 → result=0x2224, carry=0, zero=0, out_valid exactly 16 cycles after accept.
2. ADD 0xFFFF+0x0001 → result=0x0000, carry=1, zero=1; with ALU_SERIAL_OVF_EN, ADD 0x7FFF+0x0001 → 0x8000, ovf=1.
3. SUB 0x0007-0x0005 → 0x0002, carry=1; SUB 0x0005-0x0007 → 0xFFFE, carry=0.
4. AND 0xF0F0,0xFF00 → 0xF000; XNOR same operands → 0xF00F; carry=0 for both.
5. sel=010 with A=3, B=2 → err=1, result=0, out_valid 1 cycle after accept; the following ADD 1+1 → 0x0002, err=0.
6. Hold out_ready=0 for 5 cycles in DONE → result stable, in_ready=0, in_valid pulses ignored. Then pull rst_n low at bit 7 of a new RUN → all outputs 0 asynchronously, in_ready=1 after release, next request completes normally.
